// File: rtl/sha_block_arbiter_if.sv
// Requester, engine and response signals between the front-ends, the arbiter and the SHA engine.
interface sha_block_arbiter_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 3
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     req_first;
    logic [NREQ-1:0]     req_last;
    logic [NREQ*512-1:0] req_block;
    logic                eng_start;
    logic                eng_init;
    logic [511:0]        eng_w;
    logic                eng_done;
    logic [255:0]        eng_hash;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [255:0]        rsp_hash;
    logic                rsp_err;

    // Arbiter side
    modport slave (
        input  req_valid, req_first, req_last, req_block, eng_done, eng_hash, rsp_ready,
        output req_ready, eng_start, eng_init, eng_w, rsp_valid, rsp_id, rsp_hash, rsp_err
    );

    // Requester / engine / response-consumer side
    modport master (
        output req_valid, req_first, req_last, req_block, eng_done, eng_hash, rsp_ready,
        input  req_ready, eng_start, eng_init, eng_w, rsp_valid, rsp_id, rsp_hash, rsp_err
    );
endinterface

// File: rtl/sha_block_arbiter.sv
// Round-robin arbiter that sequences one shared SHA-256 compression engine across NREQ requesters,
// holding the engine for a single requester across a multi-block message.
module sha_block_arbiter #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned IDW     = 3,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic                clk,
    input logic                rst,
    sha_block_arbiter_if.slave bus
);
    localparam int unsigned BW = 512;
    localparam int unsigned HW = 256;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr, rr_nxt;
    logic [IDW-1:0]  owner, owner_nxt;
    logic [IDW-1:0]  win, sel;
    logic            lock, lock_nxt;
    logic            first_q, first_nxt;
    logic            last_q, last_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [BW-1:0]   blk_q, blk_nxt;
    logic [HW-1:0]   hash_q, hash_nxt;
    logic            err_q, err_nxt;
    logic            rsp_valid_q, eng_start_q, eng_init_q;
    logic            found, grant;
    logic [NREQ-1:0] ready_c;

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        owner_nxt = owner;
        lock_nxt  = lock;
        first_nxt = first_q;
        last_nxt  = last_q;
        cnt_nxt   = cnt;
        blk_nxt   = blk_q;
        hash_nxt  = hash_q;
        err_nxt   = err_q;
        ready_c   = '0;
        found     = 1'b0;
        win       = '0;
        grant     = 1'b0;
        sel       = owner;

        // Rotated priority: indices at or above rr first, then wrap to the low indices
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!found && bus.req_valid[j] && (j >= 32'(rr))) begin
                found = 1'b1;
                win   = IDW'(j);
            end
        end
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!found && bus.req_valid[j]) begin
                found = 1'b1;
                win   = IDW'(j);
            end
        end

        case (state)
            IDLE: begin
                if (lock) begin
                    sel = owner;
                    for (int unsigned j = 0; j < NREQ; j++) begin
                        if (IDW'(j) == owner) grant = bus.req_valid[j];
                    end
                end else begin
                    sel   = win;
                    grant = found;
                    if (found) begin
                        rr_nxt = ((32'(win) + 32'd1) >= NREQ) ? '0 : IDW'(32'(win) + 32'd1);
                    end
                end
                for (int unsigned j = 0; j < NREQ; j++) begin
                    if (grant && (IDW'(j) == sel)) begin
                        ready_c[j] = 1'b1;
                        blk_nxt    = bus.req_block[j*BW +: BW];
                        first_nxt  = bus.req_first[j];
                        last_nxt   = bus.req_last[j];
                    end
                end
                if (grant) begin
                    owner_nxt = sel;
                    state_nxt = START;
                end
            end
            START: begin
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt + CW'(1);
                if (bus.eng_done) begin
                    hash_nxt  = bus.eng_hash;
                    err_nxt   = 1'b0;
                    state_nxt = RESP;
                end else if (cnt_nxt == CW'(TIMEOUT - 1)) begin
                    hash_nxt  = '0;
                    err_nxt   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    lock_nxt  = !last_q && !err_q;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr          <= '0;
            owner       <= '0;
            lock        <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            cnt         <= '0;
            blk_q       <= '0;
            hash_q      <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            eng_start_q <= 1'b0;
            eng_init_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr          <= rr_nxt;
            owner       <= owner_nxt;
            lock        <= lock_nxt;
            first_q     <= first_nxt;
            last_q      <= last_nxt;
            cnt         <= cnt_nxt;
            blk_q       <= blk_nxt;
            hash_q      <= hash_nxt;
            err_q       <= err_nxt;
            rsp_valid_q <= (state_nxt == RESP);
            eng_start_q <= (state_nxt == START);
            eng_init_q  <= (state_nxt == START) && first_nxt;
        end
    end

    // Grant is combinational so the handshake closes in the request cycle; forced low while in reset
    assign bus.req_ready = rst ? ready_c : '0;
    assign bus.eng_start = eng_start_q;
    assign bus.eng_init  = eng_init_q;
    assign bus.eng_w     = blk_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = owner;
    assign bus.rsp_hash  = hash_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_sha_block_arbiter.sv
// Directed bench for sha_block_arbiter: grant order, lock, latency, backpressure, timeout and reset.
module tb_sha_block_arbiter;
    logic clk;
    logic rst;

    int n_cmp = 0;
    int n_bad = 0;

    logic [511:0] blk0 = {16{32'hA0A0_0001}};
    logic [511:0] blk1 = {16{32'hB1B1_0002}};

    sha_block_arbiter_if #(.NREQ(2), .IDW(3)) bus ();
    sha_block_arbiter_if #(.NREQ(2), .IDW(3)) bus2 ();

    sha_block_arbiter #(.NREQ(2), .IDW(3), .TIMEOUT(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sha_block_arbiter #(.NREQ(2), .IDW(3), .TIMEOUT(16)) dut_to (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One block through the main instance: request, start, engine done after dly cycles, response
    task automatic do_block(input string tag, input logic [1:0] v, input logic [1:0] f,
                            input logic [1:0] l, input logic [1:0] exp_rdy, input logic exp_init,
                            input int dly, input int hold, input logic [255:0] h);
        logic [511:0] exp_w;
        logic [2:0]   exp_id;
        exp_w  = exp_rdy[1] ? blk1 : blk0;
        exp_id = exp_rdy[1] ? 3'd1 : 3'd0;
        bus.req_valid = v;
        bus.req_first = f;
        bus.req_last  = l;
        #1 check({tag, "_rdy"}, 512'(bus.req_ready), 512'(exp_rdy));
        tick;
        #1;
        check({tag, "_start"}, 512'(bus.eng_start), 512'(1'b1));
        check({tag, "_init"}, 512'(bus.eng_init), 512'(exp_init));
        check({tag, "_w"}, bus.eng_w, exp_w);
        tick;
        #1;
        check({tag, "_start_once"}, 512'(bus.eng_start), 512'(1'b0));
        check({tag, "_busy_rdy"}, 512'(bus.req_ready), 512'(2'b00));
        repeat (dly - 1) tick;
        bus.eng_done  = 1'b1;
        bus.eng_hash  = h;
        bus.rsp_ready = (hold == 0);
        tick;
        bus.eng_done = 1'b0;
        #1;
        check({tag, "_rsp_valid"}, 512'(bus.rsp_valid), 512'(1'b1));
        check({tag, "_rsp_id"}, 512'(bus.rsp_id), 512'(exp_id));
        check({tag, "_rsp_hash"}, 512'(bus.rsp_hash), 512'(h));
        check({tag, "_rsp_err"}, 512'(bus.rsp_err), 512'(1'b0));
        for (int i = 0; i < hold; i++) begin
            bus.eng_done = ~i[0];
            bus.eng_hash = ~h;
            tick;
            bus.eng_done = 1'b0;
            #1;
            check({tag, "_hold_hash"}, 512'(bus.rsp_hash), 512'(h));
            check({tag, "_hold_valid"}, 512'(bus.rsp_valid), 512'(1'b1));
            check({tag, "_hold_start"}, 512'(bus.eng_start), 512'(1'b0));
            check({tag, "_hold_rdy"}, 512'(bus.req_ready), 512'(2'b00));
        end
        bus.rsp_ready = 1'b1;
        tick;
        bus.rsp_ready = 1'b0;
        #1 check({tag, "_rsp_drop"}, 512'(bus.rsp_valid), 512'(1'b0));
        bus.req_valid = '0;
    endtask

    initial begin
        rst            = 1'b0;
        bus.req_valid  = '0;
        bus.req_first  = '0;
        bus.req_last   = '0;
        bus.req_block  = {blk1, blk0};
        bus.eng_done   = 1'b0;
        bus.eng_hash   = '0;
        bus.rsp_ready  = 1'b0;
        bus2.req_valid = '0;
        bus2.req_first = '0;
        bus2.req_last  = '0;
        bus2.req_block = {blk1, blk0};
        bus2.eng_done  = 1'b0;
        bus2.eng_hash  = {8{32'hDEAD_BEEF}};
        bus2.rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_rdy", 512'(bus.req_ready), 512'(2'b00));
        check("reset_start", 512'(bus.eng_start), 512'(1'b0));
        check("reset_valid", 512'(bus.rsp_valid), 512'(1'b0));
        check("reset_w", bus.eng_w, 512'(0));
        @(negedge clk);
        rst = 1'b1;
        tick;

        // Single-block message, engine done 64 cycles after start
        do_block("single", 2'b01, 2'b01, 2'b01, 2'b01, 1'b1, 64, 0, {8{32'h1111_0001}});

        // Both valid, single-block messages; pointer sits at 1 after the previous grant to 0
        do_block("rr_a", 2'b11, 2'b11, 2'b11, 2'b10, 1'b1, 3, 0, {8{32'h2222_0001}});
        do_block("rr_b", 2'b11, 2'b11, 2'b11, 2'b01, 1'b1, 3, 0, {8{32'h2222_0002}});
        do_block("rr_c", 2'b11, 2'b11, 2'b11, 2'b10, 1'b1, 3, 0, {8{32'h2222_0003}});
        do_block("rr_d", 2'b11, 2'b11, 2'b11, 2'b01, 1'b1, 3, 0, {8{32'h2222_0004}});

        // Requester 1 three-block message while requester 0 stays valid
        do_block("lock_a", 2'b11, 2'b10, 2'b00, 2'b10, 1'b1, 4, 0, {8{32'h3333_0001}});
        do_block("lock_b", 2'b11, 2'b00, 2'b00, 2'b10, 1'b0, 4, 0, {8{32'h3333_0002}});
        do_block("lock_c", 2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 4, 0, {8{32'h3333_0003}});
        do_block("lock_rel", 2'b11, 2'b11, 2'b11, 2'b01, 1'b1, 4, 0, {8{32'h3333_0004}});

        // Response backpressure with stray engine pulses
        do_block("bp", 2'b01, 2'b01, 2'b01, 2'b01, 1'b1, 5, 10, {8{32'h4444_0001}});

        // Reset in the middle of WAIT
        bus.req_valid = 2'b01;
        bus.req_first = 2'b01;
        bus.req_last  = 2'b01;
        #1 check("rst_rdy", 512'(bus.req_ready), 512'(2'b01));
        tick;
        bus.req_valid = '0;
        tick;
        tick;
        #2 rst = 1'b0;
        #1;
        check("rst_w", bus.eng_w, 512'(0));
        check("rst_hash", 512'(bus.rsp_hash), 512'(0));
        check("rst_valid", 512'(bus.rsp_valid), 512'(1'b0));
        check("rst_start", 512'(bus.eng_start), 512'(1'b0));
        @(negedge clk);
        rst = 1'b1;
        tick;
        bus.eng_done = 1'b1;
        bus.eng_hash = {8{32'h5555_0001}};
        tick;
        bus.eng_done = 1'b0;
        #1;
        check("stray_done_valid", 512'(bus.rsp_valid), 512'(1'b0));
        check("stray_done_hash", 512'(bus.rsp_hash), 512'(0));
        do_block("post_rst", 2'b11, 2'b11, 2'b11, 2'b01, 1'b1, 5, 0, {8{32'h5555_0002}});

        // Timeout instance: engine never completes, last=0 must not leave a lock behind
        bus2.req_valid = 2'b01;
        bus2.req_first = 2'b01;
        bus2.req_last  = 2'b00;
        #1 check("to_rdy", 512'(bus2.req_ready), 512'(2'b01));
        tick;
        bus2.req_valid = '0;
        #1 check("to_start", 512'(bus2.eng_start), 512'(1'b1));
        repeat (15) tick;
        #1 check("to_early", 512'(bus2.rsp_valid), 512'(1'b0));
        tick;
        #1;
        check("to_valid", 512'(bus2.rsp_valid), 512'(1'b1));
        check("to_err", 512'(bus2.rsp_err), 512'(1'b1));
        check("to_hash", 512'(bus2.rsp_hash), 512'(0));
        check("to_id", 512'(bus2.rsp_id), 512'(0));
        bus2.rsp_ready = 1'b1;
        tick;
        bus2.rsp_ready = 1'b0;
        bus2.req_valid = 2'b10;
        bus2.req_first = 2'b10;
        bus2.req_last  = 2'b10;
        #1 check("to_unlock", 512'(bus2.req_ready), 512'(2'b10));
        bus2.req_valid = '0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sha_block_arbiter.md
Name: sha_block_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one SHA-256 compression engine between NREQ requesters.
- Accepts 512-bit message blocks from each requester and sequences the engine: init/chain, start pulse, wait for done.
- Returns the engine hash to the owning requester.
- Locks the engine to one requester across a multi-block message until its last block completes. Sits between requester front-ends and the sha_transform-class engine.

Parameters:
NREQ, 2, number of requesters (2..8)
IDW, 3, width of requester index (>= clog2(NREQ))
TIMEOUT, 1024, max cycles in WAIT before declaring engine hang

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
req_valid  input  NREQ  per-requester block valid
req_ready  output  NREQ  per-requester accept, one-hot or zero
req_first  input  NREQ  block is first of a message (engine loads IV)
req_last  input  NREQ  block is last of a message
req_block  input  NREQ*512  per-requester block, requester i at [i*512 +: 512], word 0 in MSBs
eng_start  output  1  one-cycle start pulse to engine
eng_init  output  1  engine reloads IV before this block; valid with eng_start
eng_w  output  512  block to engine, held stable from START until leaving WAIT
eng_done  input  1  engine completion pulse
eng_hash  input  256  engine hash, valid with eng_done
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_id  output  IDW  owning requester of response
rsp_hash  output  256  latched hash
rsp_err  output  1  response is a timeout

Behaviour:
- Reset: all outputs 0.
  - State IDLE; rr pointer 0; lock clear; counter 0.
  - Reset mid-operation returns to IDLE immediately. The engine is not aborted; any eng_done arriving later in IDLE is ignored.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE, no lock:
  - Winner = first i with req_valid[i] set, searching from rr pointer upward mod NREQ.
  - req_ready[winner]=1 combinationally; handshake completes that cycle.
  - Latch block, first, last, and owner=winner. rr pointer <= winner+1 mod NREQ.
  - Go to START.
  - No valid requests: stay in IDLE, req_ready=0.
- IDLE, locked:
  - Only the owner is eligible; req_ready[owner]=req_valid[owner]; other requesters are stalled.
  - rr pointer is not updated on locked grants.
- START: eng_start=1 and eng_init=latched first for exactly one cycle; counter cleared; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - eng_done=1: latch eng_hash into rsp_hash, rsp_err=0, go to RESP.
  - Counter reaches TIMEOUT-1 with no done: rsp_hash=0, rsp_err=1, go to RESP.
  - eng_done and timeout in the same cycle: done wins.
- RESP:
  - rsp_valid=1; rsp_id=owner; rsp_hash and rsp_err held stable until rsp_ready.
  - On rsp_valid and rsp_ready: rsp_valid=0 next cycle, go to IDLE.
  - Lock update at this handshake: set if latched last=0 and rsp_err=0; clear if last=1 or rsp_err=1.
- eng_done outside WAIT is ignored.
- eng_start is never reissued before leaving RESP.
- First/last handling:
  - A locked owner presenting first=1 is accepted; eng_init=1 restarts the message.
  - first=1 and last=1 together is a single-block message; no lock is taken.
- Latency:
  - Handshake at cycle T.
  - eng_start at T+1.
  - eng_done at cycle D gives rsp_valid at D+1.
  - With rsp_ready held high, next req_ready is possible at D+2.
- Throughput: one block in flight; no buffering beyond the single latched block.
- eng_w changes only on an accepted request.

Test Plan:
- Single block: req_valid[0], first=1, last=1; engine done 64 cycles after start. Expect req_ready[0] at T, eng_start and eng_init=1 at T+1, rsp_valid at done+1, rsp_id=0, rsp_hash=eng_hash, lock clear.
- Round robin: req_valid=2'b11 held, all blocks single-block. Expect grants in order 0,1,0,1; req_ready never has two bits set.
- Lock: requester 1 sends a 3-block message (first, mid, last) while requester 0 is continuously valid.
  - Expect three consecutive grants to 1.
  - eng_init=1 only on the first block.
  - Requester 0 is granted only after the third RESP handshake.
- Timeout: TIMEOUT=16, engine never asserts done. Expect rsp_valid 16 cycles after START, rsp_err=1, rsp_hash=0, lock released even though last=0.
- Backpressure and ignored done: hold rsp_ready=0 for 10 cycles in RESP and pulse eng_done meanwhile. Expect rsp_hash unchanged, no new req_ready, no eng_start.
- Reset mid-WAIT: assert rst=0 asynchronously. Expect outputs 0 immediately; after release, a stray eng_done is ignored, rr pointer=0, and the next grant goes to requester 0.
